sdram_arbiter: RTL and testbench

Shares one sdram_ctrl internal interface between NUM_PORTS requesters, such as a CPU data bus, an instruction fetch bus and a video DMA engine. Arbitration is round-robin with an optional hold limit, so a streaming port cannot starve the others. A port switch happens only after the controller reports idle. This guarantees that in-flight read data (vld) and acks are routed to the port that issued them.

---
 rtl/sdram_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_sdram_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one sdram_ctrl internal interface between NUM_PORTS requesters.
// Latency: 1 cycle from acc_i to ctrl_acc_o; one idle bubble between consecutive grants.
// Backpressure: a non-granted port keeps acc_i high and waits; a port is never switched until ctrl_idle_i.
//
// Ports:
//   sdram_clk, sdram_rst       clock, synchronous active-high reset
//   acc_i/we_i/dv_i            per-port request, write enable, write-data valid (one bit per port)
//   adr_i/dat_i/sel_i          per-port address (32b), write data (16b), byte select (2b), port p at slice p
//   ack_o/vld_o                per-port ack and read-data valid, only the granted port ever sees them
//   dat_o/adr_o                read data/address from the controller, broadcast to every port
//   grant_o                    one-hot current owner (status)
//   ctrl_*                     single-master interface towards sdram_ctrl
module sdram_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int MAX_HOLD   = 0,
  parameter int HOLD_WIDTH = 16
) (
  input  logic                    sdram_clk,
  input  logic                    sdram_rst,

  input  logic [NUM_PORTS-1:0]    acc_i,
  input  logic [NUM_PORTS-1:0]    we_i,
  input  logic [NUM_PORTS-1:0]    dv_i,
  input  logic [32*NUM_PORTS-1:0] adr_i,
  input  logic [16*NUM_PORTS-1:0] dat_i,
  input  logic [2*NUM_PORTS-1:0]  sel_i,
  output logic [NUM_PORTS-1:0]    ack_o,
  output logic [NUM_PORTS-1:0]    vld_o,
  output logic [15:0]             dat_o,
  output logic [31:0]             adr_o,
  output logic [NUM_PORTS-1:0]    grant_o,

  input  logic                    ctrl_idle_i,
  output logic                    ctrl_acc_o,
  output logic                    ctrl_we_o,
  output logic                    ctrl_dv_o,
  output logic [31:0]             ctrl_adr_o,
  output logic [15:0]             ctrl_dat_o,
  output logic [1:0]              ctrl_sel_o,
  input  logic                    ctrl_ack_i,
  input  logic                    ctrl_vld_i,
  input  logic [15:0]             ctrl_dat_i,
  input  logic [31:0]             ctrl_adr_i
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [IDX_W-1:0]      g, g_nxt;
  logic [IDX_W-1:0]      last, last_nxt;
  logic [NUM_PORTS-1:0]  grant, grant_nxt;
  logic [HOLD_WIDTH-1:0] hold_cnt, hold_nxt;

  // Per-port slices unpacked so port g can be selected with a plain index.
  logic [31:0] adr_arr [NUM_PORTS];
  logic [15:0] dat_arr [NUM_PORTS];
  logic [1:0]  sel_arr [NUM_PORTS];

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      adr_arr[p] = adr_i[32*p +: 32];
      dat_arr[p] = dat_i[16*p +: 16];
      sel_arr[p] = sel_i[2*p +: 2];
    end
  end

  // Round-robin pick: first requester after the last owner, wrapping.
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] cand;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = last;
    cand       = last;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = IDX_W'((int'(last) + k) % NUM_PORTS);
      if (!pick_found && acc_i[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Hold limit reached: the owner has had MAX_HOLD grant cycles including this one.
  logic hold_expired;

  generate
    if (MAX_HOLD == 0) begin : g_no_limit
      assign hold_expired = 1'b0;
    end else if (MAX_HOLD == 1) begin : g_limit_one
      assign hold_expired = 1'b1;
    end else begin : g_limit
      localparam logic [HOLD_WIDTH-1:0] HOLD_LIM = HOLD_WIDTH'(MAX_HOLD - 1);
      assign hold_expired = (hold_cnt >= HOLD_LIM);
    end
  endgenerate

  logic other_req;
  logic preempt;

  assign other_req = |(acc_i & ~grant);
  assign preempt   = hold_expired && other_req;

  // Next-state and output decode. ctrl_acc_o depends only on state and acc_i,
  // never on ctrl_idle_i.
  logic route;

  always_comb begin
    state_nxt  = state;
    g_nxt      = g;
    last_nxt   = last;
    grant_nxt  = grant;
    hold_nxt   = hold_cnt;
    route      = 1'b0;
    ctrl_acc_o = 1'b0;
    ctrl_dv_o  = 1'b0;
    ctrl_we_o  = 1'b0;
    ctrl_adr_o = '0;
    ctrl_dat_o = '0;
    ctrl_sel_o = '0;
    ack_o      = '0;
    vld_o      = '0;

    case (state)
      IDLE: begin
        if (pick_found && ctrl_idle_i) begin
          state_nxt           = GRANT;
          g_nxt               = pick_idx;
          last_nxt            = pick_idx;
          grant_nxt           = '0;
          grant_nxt[pick_idx] = 1'b1;
          hold_nxt            = '0;
        end
      end

      GRANT: begin
        route      = 1'b1;
        ctrl_acc_o = acc_i[g];
        ctrl_dv_o  = dv_i[g];
        if (!(&hold_cnt)) begin
          hold_nxt = hold_cnt + 1'b1;
        end
        // Release wins over everything; preemption only matters while still requesting.
        if (!acc_i[g] || preempt) begin
          state_nxt = DRAIN;
        end
      end

      DRAIN: begin
        // Late acks and read beats of the open access still belong to port g.
        route = 1'b1;
        if (ctrl_idle_i) begin
          state_nxt = IDLE;
          grant_nxt = '0;
        end
      end

      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase

    if (route) begin
      ctrl_we_o  = we_i[g];
      ctrl_adr_o = adr_arr[g];
      ctrl_dat_o = dat_arr[g];
      ctrl_sel_o = sel_arr[g];
      ack_o[g]   = ctrl_ack_i;
      vld_o[g]   = ctrl_vld_i;
    end
  end

  always_ff @(posedge sdram_clk) begin
    if (sdram_rst) begin
      state    <= IDLE;
      g        <= '0;
      last     <= IDX_W'(NUM_PORTS - 1);
      grant    <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      g        <= g_nxt;
      last     <= last_nxt;
      grant    <= grant_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  assign grant_o = grant;
  assign dat_o   = ctrl_dat_i;
  assign adr_o   = ctrl_adr_i;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with three ports and a hold limit of four cycles.
module tb_sdram_arbiter;

  logic        sdram_clk;
  logic        sdram_rst;
  logic [2:0]  acc_i, we_i, dv_i;
  logic [95:0] adr_i;
  logic [47:0] dat_i;
  logic [5:0]  sel_i;
  logic [2:0]  ack_o, vld_o, grant_o;
  logic [15:0] dat_o;
  logic [31:0] adr_o;
  logic        ctrl_idle_i, ctrl_acc_o, ctrl_we_o, ctrl_dv_o;
  logic [31:0] ctrl_adr_o;
  logic [15:0] ctrl_dat_o;
  logic [1:0]  ctrl_sel_o;
  logic        ctrl_ack_i, ctrl_vld_i;
  logic [15:0] ctrl_dat_i;
  logic [31:0] ctrl_adr_i;

  sdram_arbiter #(
    .NUM_PORTS (3),
    .MAX_HOLD  (4),
    .HOLD_WIDTH(16)
  ) dut (
    .sdram_clk  (sdram_clk),
    .sdram_rst  (sdram_rst),
    .acc_i      (acc_i),
    .we_i       (we_i),
    .dv_i       (dv_i),
    .adr_i      (adr_i),
    .dat_i      (dat_i),
    .sel_i      (sel_i),
    .ack_o      (ack_o),
    .vld_o      (vld_o),
    .dat_o      (dat_o),
    .adr_o      (adr_o),
    .grant_o    (grant_o),
    .ctrl_idle_i(ctrl_idle_i),
    .ctrl_acc_o (ctrl_acc_o),
    .ctrl_we_o  (ctrl_we_o),
    .ctrl_dv_o  (ctrl_dv_o),
    .ctrl_adr_o (ctrl_adr_o),
    .ctrl_dat_o (ctrl_dat_o),
    .ctrl_sel_o (ctrl_sel_o),
    .ctrl_ack_i (ctrl_ack_i),
    .ctrl_vld_i (ctrl_vld_i),
    .ctrl_dat_i (ctrl_dat_i),
    .ctrl_adr_i (ctrl_adr_i)
  );

  initial sdram_clk = 1'b0;
  always #5 sdram_clk = ~sdram_clk;

  typedef struct {
    string      name;
    logic       rst;
    logic [2:0] acc;
    logic [2:0] we;
    logic       idle;
    logic       cack;
    logic       cvld;
    logic [2:0] eg;     // expected grant_o
    logic       ecacc;  // expected ctrl_acc_o
    logic [2:0] eack;
    logic [2:0] evld;
  } vec_t;

  vec_t tbl[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic add(input string name, input logic rst, input logic [2:0] acc, input logic [2:0] we,
                     input logic idle, input logic cack, input logic cvld,
                     input logic [2:0] eg, input logic ecacc, input logic [2:0] eack, input logic [2:0] evld);
    vec_t v;
    v.name = name; v.rst = rst; v.acc = acc; v.we = we;
    v.idle = idle; v.cack = cack; v.cvld = cvld;
    v.eg = eg; v.ecacc = ecacc; v.eack = eack; v.evld = evld;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int n);
    int idx;
    logic [31:0] e_adr;
    logic [15:0] e_dat;
    logic [1:0]  e_sel;
    idx = 0;
    @(negedge sdram_clk);
    sdram_rst   = v.rst;
    acc_i       = v.acc;
    we_i        = v.we;
    dv_i        = v.acc & v.we;
    ctrl_idle_i = v.idle;
    ctrl_ack_i  = v.cack;
    ctrl_vld_i  = v.cvld;
    ctrl_dat_i  = 16'h5A00 + 16'(n);
    ctrl_adr_i  = 32'hF000_0000 + 32'(n);
    #1;
    vectors++;
    for (int p = 0; p < 3; p++) if (v.eg[p]) idx = p;
    e_adr = 32'h100 * (idx + 1);
    e_dat = 16'hA1 + 16'h11 * 16'(idx);
    e_sel = 2'(idx + 1);
    chk($sformatf("%s[%0d] grant_o", v.name, n), 32'(grant_o), 32'(v.eg));
    chk($sformatf("%s[%0d] ctrl_acc_o", v.name, n), 32'(ctrl_acc_o), 32'(v.ecacc));
    chk($sformatf("%s[%0d] ack_o", v.name, n), 32'(ack_o), 32'(v.eack));
    chk($sformatf("%s[%0d] vld_o", v.name, n), 32'(vld_o), 32'(v.evld));
    chk($sformatf("%s[%0d] ctrl_dv_o", v.name, n), 32'(ctrl_dv_o), v.ecacc ? 32'(v.we[idx]) : 32'd0);
    chk($sformatf("%s[%0d] dat_o", v.name, n), 32'(dat_o), 32'(16'h5A00 + 16'(n)));
    chk($sformatf("%s[%0d] adr_o", v.name, n), adr_o, 32'hF000_0000 + 32'(n));
    if (v.eg == 3'b000) begin
      chk($sformatf("%s[%0d] idle ctrl_we_o", v.name, n), 32'(ctrl_we_o), 32'd0);
      chk($sformatf("%s[%0d] idle ctrl_adr_o", v.name, n), ctrl_adr_o, 32'd0);
      chk($sformatf("%s[%0d] idle ctrl_dat_o", v.name, n), 32'(ctrl_dat_o), 32'd0);
      chk($sformatf("%s[%0d] idle ctrl_sel_o", v.name, n), 32'(ctrl_sel_o), 32'd0);
    end else if (v.ecacc) begin
      chk($sformatf("%s[%0d] ctrl_we_o", v.name, n), 32'(ctrl_we_o), 32'(v.we[idx]));
      chk($sformatf("%s[%0d] ctrl_adr_o", v.name, n), ctrl_adr_o, e_adr);
      chk($sformatf("%s[%0d] ctrl_dat_o", v.name, n), 32'(ctrl_dat_o), 32'(e_dat));
      chk($sformatf("%s[%0d] ctrl_sel_o", v.name, n), 32'(ctrl_sel_o), 32'(e_sel));
    end
  endtask

  initial begin
    logic [2:0] oh, rel;
    logic       found;
    int         lat;

    sdram_rst   = 1'b1;
    acc_i       = '0;
    we_i        = '0;
    dv_i        = '0;
    adr_i       = {32'h300, 32'h200, 32'h100};
    dat_i       = {16'hC3, 16'hB2, 16'hA1};
    sel_i       = {2'b11, 2'b10, 2'b01};
    ctrl_idle_i = 1'b1;
    ctrl_ack_i  = 1'b0;
    ctrl_vld_i  = 1'b0;
    ctrl_dat_i  = '0;
    ctrl_adr_i  = '0;
    repeat (2) @(posedge sdram_clk);

    //   name            rst acc     we      idle ack vld  grant   cacc eack    evld
    // single read with an 8-beat burst
    add("rst",           1, 3'b000, 3'b000, 1, 0, 0, 3'b000, 0, 3'b000, 3'b000);
    add("rd_req",        0, 3'b001, 3'b000, 1, 0, 0, 3'b000, 0, 3'b000, 3'b000);
    add("rd_grant",      0, 3'b001, 3'b000, 1, 0, 0, 3'b001, 1, 3'b000, 3'b000);
    add("rd_beat",       0, 3'b000, 3'b000, 0, 0, 1, 3'b001, 0, 3'b000, 3'b001);
    for (int i = 0; i < 7; i++)
      add("rd_beat",     0, 3'b000, 3'b000, 0, 0, 1, 3'b001, 0, 3'b000, 3'b001);
    add("rd_drained",    0, 3'b000, 3'b000, 1, 0, 0, 3'b001, 0, 3'b000, 3'b000);
    add("idle_ignore",   0, 3'b000, 3'b000, 1, 1, 1, 3'b000, 0, 3'b000, 3'b000);
    // simultaneous requests after reset
    add("rst2",          1, 3'b011, 3'b000, 1, 0, 0, 3'b000, 0, 3'b000, 3'b000);
    add("sim_req",       0, 3'b011, 3'b000, 1, 0, 0, 3'b000, 0, 3'b000, 3'b000);
    add("sim_g0",        0, 3'b011, 3'b000, 1, 0, 0, 3'b001, 1, 3'b000, 3'b000);
    add("sim_rel0",      0, 3'b010, 3'b000, 1, 0, 0, 3'b001, 0, 3'b000, 3'b000);
    add("sim_drain0",    0, 3'b010, 3'b000, 1, 0, 0, 3'b001, 0, 3'b000, 3'b000);
    add("sim_bubble",    0, 3'b010, 3'b000, 1, 0, 0, 3'b000, 0, 3'b000, 3'b000);
    add("sim_g1",        0, 3'b010, 3'b000, 1, 0, 0, 3'b010, 1, 3'b000, 3'b000);
    add("sim_rel1",      0, 3'b000, 3'b000, 1, 0, 0, 3'b010, 0, 3'b000, 3'b000);
    add("sim_drain1",    0, 3'b000, 3'b000, 1, 0, 0, 3'b010, 0, 3'b000, 3'b000);
    // round robin, every port writing and releasing after one ack: 0,1,2,0,1,2
    add("rst3",          1, 3'b111, 3'b111, 1, 0, 0, 3'b000, 0, 3'b000, 3'b000);
    add("rr_req",        0, 3'b111, 3'b111, 1, 0, 0, 3'b000, 0, 3'b000, 3'b000);
    for (int k = 0; k < 6; k++) begin
      oh  = 3'b001 << (k % 3);
      rel = (k == 5) ? 3'b000 : (3'b111 & ~oh);
      add("rr_grant",    0, 3'b111, 3'b111, 1, 1, 0, oh,     1, oh,     3'b000);
      add("rr_rel",      0, rel,    3'b111, 1, 0, 0, oh,     0, 3'b000, 3'b000);
      add("rr_drain",    0, rel,    3'b111, 1, 0, 0, oh,     0, 3'b000, 3'b000);
      if (k < 5)
        add("rr_bubble", 0, 3'b111, 3'b111, 1, 0, 0, 3'b000, 0, 3'b000, 3'b000);
    end
    // preemption after four grant cycles
    add("rst4",          1, 3'b000, 3'b000, 1, 0, 0, 3'b000, 0, 3'b000, 3'b000);
    add("pe_req",        0, 3'b001, 3'b000, 1, 0, 0, 3'b000, 0, 3'b000, 3'b000);
    for (int i = 0; i < 4; i++)
      add("pe_hold",     0, 3'b011, 3'b000, 1, 0, 0, 3'b001, 1, 3'b000, 3'b000);
    add("pe_drain",      0, 3'b011, 3'b000, 0, 0, 0, 3'b001, 0, 3'b000, 3'b000);
    add("pe_drain_idle", 0, 3'b011, 3'b000, 1, 0, 0, 3'b001, 0, 3'b000, 3'b000);
    add("pe_bubble",     0, 3'b011, 3'b000, 1, 0, 0, 3'b000, 0, 3'b000, 3'b000);
    add("pe_g1",         0, 3'b011, 3'b000, 1, 0, 0, 3'b010, 1, 3'b000, 3'b000);
    add("pe_rel1",       0, 3'b001, 3'b000, 1, 0, 0, 3'b010, 0, 3'b000, 3'b000);
    add("pe_drain1",     0, 3'b001, 3'b000, 1, 0, 0, 3'b010, 0, 3'b000, 3'b000);
    add("pe_bubble2",    0, 3'b001, 3'b000, 1, 0, 0, 3'b000, 0, 3'b000, 3'b000);
    add("pe_regrant0",   0, 3'b001, 3'b000, 1, 0, 0, 3'b001, 1, 3'b000, 3'b000);
    add("pe_rel0",       0, 3'b000, 3'b000, 1, 0, 0, 3'b001, 0, 3'b000, 3'b000);
    add("pe_drain0",     0, 3'b000, 3'b000, 1, 0, 0, 3'b001, 0, 3'b000, 3'b000);
    // drain held open by a busy controller, release and new request together
    add("dw_req",        0, 3'b001, 3'b000, 1, 0, 0, 3'b000, 0, 3'b000, 3'b000);
    add("dw_g0",         0, 3'b001, 3'b000, 1, 0, 0, 3'b001, 1, 3'b000, 3'b000);
    add("dw_rel",        0, 3'b010, 3'b000, 0, 0, 1, 3'b001, 0, 3'b000, 3'b001);
    for (int i = 0; i < 4; i++)
      add("dw_drain",    0, 3'b010, 3'b000, 0, 0, 1'(i % 2), 3'b001, 0, 3'b000, 3'((i % 2)));
    add("dw_idle",       0, 3'b010, 3'b000, 1, 0, 0, 3'b001, 0, 3'b000, 3'b000);
    add("dw_bubble",     0, 3'b010, 3'b000, 1, 0, 0, 3'b000, 0, 3'b000, 3'b000);
    add("dw_g1",         0, 3'b010, 3'b010, 1, 0, 0, 3'b010, 1, 3'b000, 3'b000);
    // reset during port1 write
    add("rst_mid",       1, 3'b010, 3'b010, 1, 1, 0, 3'b010, 1, 3'b010, 3'b000);
    add("rst_after",     0, 3'b011, 3'b010, 1, 1, 0, 3'b000, 0, 3'b000, 3'b000);
    add("rst_p0_first",  0, 3'b011, 3'b010, 1, 0, 0, 3'b001, 1, 3'b000, 3'b000);
    add("rst_rel",       0, 3'b000, 3'b000, 1, 0, 0, 3'b001, 0, 3'b000, 3'b000);
    add("rst_drain",     0, 3'b000, 3'b000, 1, 0, 0, 3'b001, 0, 3'b000, 3'b000);

    for (int n = 0; n < tbl.size(); n++) apply(tbl[n], n);

    // No grant while the controller is busy, then a 1-cycle grant once idle.
    @(negedge sdram_clk);
    sdram_rst   = 1'b0;
    acc_i       = 3'b100;
    we_i        = 3'b000;
    dv_i        = 3'b000;
    ctrl_idle_i = 1'b0;
    ctrl_ack_i  = 1'b0;
    ctrl_vld_i  = 1'b0;
    repeat (3) begin
      @(negedge sdram_clk);
      #1;
      vectors++;
      chk("busy_hold grant_o", 32'(grant_o), 32'd0);
      chk("busy_hold ctrl_acc_o", 32'(ctrl_acc_o), 32'd0);
    end
    ctrl_idle_i = 1'b1;
    found = 1'b0;
    lat   = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge sdram_clk);
      #1;
      lat = i + 1;
      if (grant_o == 3'b100) found = 1'b1;
    end
    vectors++;
    chk("port2_grant found", 32'(found), 32'd1);
    chk("port2_grant latency", 32'(lat), 32'd1);
    chk("port2_grant ctrl_acc_o", 32'(ctrl_acc_o), 32'd1);
    chk("port2_grant ctrl_adr_o", ctrl_adr_o, 32'h300);
    acc_i = 3'b000;
    repeat (3) @(negedge sdram_clk);
    #1;
    vectors++;
    chk("port2_release grant_o", 32'(grant_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
